// File: rtl/multicycle_adder_pkg.sv
// multicycle_adder_pkg: shared state encoding and sizing helpers
package multicycle_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nchunk_of(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int idx_w_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry slice
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: N-bit add/subtract evaluated CHUNK bits per clock
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
  localparam int IW = idx_w_of(NCHUNK);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic carry, cout_r, ovf_r, last, co, cm;
  logic [CHUNK-1:0] xs, ys, s;
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x(xs), .y(ys), .ci(carry), .s(s), .co(co), .c_msb_in(cm)
  );
  always_comb begin
    xs = a_r[idx*CHUNK +: CHUNK];
    ys = b_r[idx*CHUNK +: CHUNK];
    last = idx == IW'(NCHUNK - 1);
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? RUN : IDLE;
      RUN:     state_n = last ? DONE : RUN;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_r   <= a;
        b_r   <= sub ? ~b : b;
        carry <= sub | cin;
        idx   <= '0;
      end else if (state == RUN) begin
        sum_r[idx*CHUNK +: CHUNK] <= s;
        carry <= co;
        idx   <= idx + 1'b1;
        if (last) begin
          cout_r <= co;
          ovf_r  <= co ^ cm;
        end
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
endmodule
